block_packer: RTL and testbench

BLOCK_PACKER -- requirements
Module: block_packer

---
 rtl/block_packer_if.sv | 31 +++
 rtl/block_packer.sv | 105 ++++++++++
 tb/tb_block_packer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/block_packer_if.sv
// Byte-stream and cipher-side signal bundle for block_packer.
// The packer uses the slave view; the upstream source/cipher model uses master.
interface block_packer_if #(
  parameter int COUNT_WIDTH = 16
);
  logic [7:0]             byte_in;
  logic                   byte_valid_in;
  logic                   byte_ready_out;
  logic                   flush_in;
  logic [127:0]           key_in;
  logic                   cipher_start_out;
  logic [127:0]           cipher_block_out;
  logic [127:0]           cipher_key_out;
  logic                   cipher_valid_in;
  logic [127:0]           cipher_result_in;
  logic [127:0]           result_out;
  logic                   result_valid_out;
  logic [COUNT_WIDTH-1:0] block_count_out;

  modport slave (
    input  byte_in, byte_valid_in, flush_in, key_in, cipher_valid_in, cipher_result_in,
    output byte_ready_out, cipher_start_out, cipher_block_out, cipher_key_out,
           result_out, result_valid_out, block_count_out
  );

  modport master (
    output byte_in, byte_valid_in, flush_in, key_in, cipher_valid_in, cipher_result_in,
    input  byte_ready_out, cipher_start_out, cipher_block_out, cipher_key_out,
           result_out, result_valid_out, block_count_out
  );
endinterface

// File: rtl/block_packer.sv
// Packs a byte stream MSB-first into 128-bit blocks, pads partial blocks on flush,
// launches each block to an external cipher and captures the returned ciphertext.
module block_packer #(
  parameter logic [7:0] PAD_BYTE    = 8'h00,
  parameter int         COUNT_WIDTH = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  block_packer_if.slave  bus
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [3:0]             fill_q, fill_d;
  logic [127:0]           block_q, block_d;
  logic [127:0]           key_q, key_d;
  logic [127:0]           result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic       xfer;
  logic [3:0] slot;
  logic [4:0] pad_from;

  assign xfer = bus.byte_valid_in && (state_q == ST_COLLECT);
  // Byte k lands at bits [127-8k -: 8], i.e. the (15-k)-th byte lane from the bottom.
  assign slot = 4'd15 - fill_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d        = state_q;
    fill_d         = fill_q;
    block_d        = block_q;
    key_d          = key_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    count_d        = count_q;
    pad_from       = {1'b0, fill_q} + {4'd0, xfer};

    case (state_q)
      ST_COLLECT: begin
        if (xfer) begin
          block_d[{slot, 3'b000} +: 8] = bus.byte_in;
          fill_d                       = fill_q + 4'd1;
        end
        if (xfer && fill_q == 4'd15) begin
          state_d = ST_LAUNCH;
          key_d   = bus.key_in;
        end else if (bus.flush_in && (xfer || fill_q != 4'd0)) begin
          // A byte arriving with the flush is written above; padding starts after it.
          for (int i = 0; i < 16; i++) begin
            if (5'(i) >= pad_from) block_d[8*(15-i) +: 8] = PAD_BYTE;
          end
          state_d = ST_LAUNCH;
          key_d   = bus.key_in;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.cipher_valid_in) begin
          result_d       = bus.cipher_result_in;
          result_valid_d = 1'b1;
          count_d        = count_q + 1'b1;
          fill_d         = 4'd0;
          state_d        = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (rst_in) begin
      state_q        <= ST_COLLECT;
      fill_q         <= 4'd0;
      block_q        <= '0;
      key_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      block_q        <= block_d;
      key_q          <= key_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      count_q        <= count_d;
    end
  end

  // block_q and key_q are only written in COLLECT, so they hold from launch to capture.
  assign bus.byte_ready_out   = (state_q == ST_COLLECT);
  assign bus.cipher_start_out = (state_q == ST_LAUNCH);
  assign bus.cipher_block_out = block_q;
  assign bus.cipher_key_out   = key_q;
  assign bus.result_out       = result_q;
  assign bus.result_valid_out = result_valid_q;
  assign bus.block_count_out  = count_q;

endmodule

// File: tb/tb_block_packer.sv
// Directed bench for block_packer: a main instance (non-zero pad byte) and a
// COUNT_WIDTH=2 instance sharing the same stimulus for the counter wrap.
module tb_block_packer;

  localparam logic [7:0] PAD = 8'h5C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  block_packer_if #(.COUNT_WIDTH(16)) bus ();
  block_packer_if #(.COUNT_WIDTH(2))  bus_w ();

  assign bus_w.byte_in          = bus.byte_in;
  assign bus_w.byte_valid_in    = bus.byte_valid_in;
  assign bus_w.flush_in         = bus.flush_in;
  assign bus_w.key_in           = bus.key_in;
  assign bus_w.cipher_valid_in  = bus.cipher_valid_in;
  assign bus_w.cipher_result_in = bus.cipher_result_in;

  block_packer #(.PAD_BYTE(PAD), .COUNT_WIDTH(16)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  block_packer #(.COUNT_WIDTH(2)) dut_w (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_w)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic fl);
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    bus.flush_in      = fl;
    step();
    bus.byte_valid_in = 1'b0;
    bus.flush_in      = 1'b0;
  endtask

  // 16 bytes base, base+1, ...; leaves the bench in the LAUNCH cycle.
  task automatic push_full(input logic [7:0] base, input logic fl_last);
    for (int i = 0; i < 16; i++) push(base + 8'(i), (i == 15) ? fl_last : 1'b0);
  endtask

  function automatic logic [127:0] seq_block(input logic [7:0] base);
    logic [127:0] blk;
    for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = base + 8'(i);
    return blk;
  endfunction

  // Called in the WAIT cycle; ends one cycle after the result pulse.
  task automatic complete(input logic [127:0] res, input int exp_cnt);
    bus.cipher_result_in = res;
    bus.cipher_valid_in  = 1'b1;
    step();
    bus.cipher_valid_in  = 1'b0;
    check("res_valid_pulse", bus.result_valid_out, 1'b1);
    check("result", bus.result_out, res);
    check("count", bus.block_count_out, 128'(exp_cnt));
    check("ready_after_res", bus.byte_ready_out, 1'b1);
    step();
    check("res_valid_low", bus.result_valid_out, 1'b0);
    check("result_hold", bus.result_out, res);
  endtask

  initial begin
    logic [127:0] key;
    logic [127:0] r1;
    int           wrap_exp[5];
    key = 128'h000102030405060708090a0b0c0d0e0f;
    r1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    wrap_exp = '{1, 2, 3, 0, 1};

    bus.byte_in = '0; bus.byte_valid_in = 1'b0; bus.flush_in = 1'b0;
    bus.key_in = key; bus.cipher_valid_in = 1'b0; bus.cipher_result_in = '0;

    step(); step();
    rst = 1'b0;
    check("rst_ready", bus.byte_ready_out, 1'b1);
    check("rst_start", bus.cipher_start_out, 1'b0);
    check("rst_res_valid", bus.result_valid_out, 1'b0);
    check("rst_block", bus.cipher_block_out, '0);
    check("rst_key", bus.cipher_key_out, '0);
    check("rst_result", bus.result_out, '0);
    check("rst_count", bus.block_count_out, '0);

    // Full block, then backpressure while waiting on the cipher
    push_full(8'h00, 1'b0);
    check("full_start", bus.cipher_start_out, 1'b1);
    check("full_block", bus.cipher_block_out, key);
    check("full_key", bus.cipher_key_out, key);
    bus.byte_in = 8'hEE; bus.byte_valid_in = 1'b1; bus.flush_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_start_low", bus.cipher_start_out, 1'b0);
      check("bp_ready_low", bus.byte_ready_out, 1'b0);
      check("bp_block_stable", bus.cipher_block_out, key);
      check("bp_key_stable", bus.cipher_key_out, key);
    end
    bus.byte_valid_in = 1'b0; bus.flush_in = 1'b0;
    complete(r1, 1);

    // Partial block flushed after 3 bytes; collection restarted at count 0
    push(8'hAA, 1'b0); push(8'hBB, 1'b0); push(8'hCC, 1'b0);
    check("partial_no_start", bus.cipher_start_out, 1'b0);
    bus.flush_in = 1'b1; step(); bus.flush_in = 1'b0;
    check("flush_start", bus.cipher_start_out, 1'b1);
    check("flush_block", bus.cipher_block_out, {24'hAABBCC, {13{PAD}}});
    bus.flush_in = 1'b1; step(); bus.flush_in = 1'b0;
    check("flush_in_wait_ign", bus.cipher_start_out, 1'b0);
    complete(128'h1111, 2);

    // Flush at count 0 and stray cipher_valid_in in COLLECT are both ignored
    bus.flush_in = 1'b1; bus.cipher_valid_in = 1'b1; bus.cipher_result_in = 128'hDEAD;
    step();
    bus.flush_in = 1'b0; bus.cipher_valid_in = 1'b0;
    step();
    check("flush0_no_start", bus.cipher_start_out, 1'b0);
    check("flush0_ready", bus.byte_ready_out, 1'b1);
    check("stray_valid_ign", bus.result_valid_out, 1'b0);
    check("stray_count", bus.block_count_out, 128'd2);
    check("stray_result", bus.result_out, 128'h1111);

    // 16th byte with flush: plain launch, no padding
    push_full(8'h10, 1'b1);
    check("b16fl_start", bus.cipher_start_out, 1'b1);
    check("b16fl_block", bus.cipher_block_out, seq_block(8'h10));
    step();
    check("b16fl_single", bus.cipher_start_out, 1'b0);
    complete(128'h2222, 3);

    // Byte with flush at count 4: 5 data bytes then 11 pads
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
    push(8'h05, 1'b1);
    check("b5fl_start", bus.cipher_start_out, 1'b1);
    check("b5fl_block", bus.cipher_block_out, {40'h0102030405, {11{PAD}}});
    step();
    complete(128'h3333, 4);

    // Reset while waiting on the cipher; the late completion must be dropped
    push(8'h77, 1'b1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rstw_ready", bus.byte_ready_out, 1'b1);
    check("rstw_count", bus.block_count_out, '0);
    check("rstw_block", bus.cipher_block_out, '0);
    bus.cipher_result_in = 128'h4444; bus.cipher_valid_in = 1'b1;
    step();
    bus.cipher_valid_in = 1'b0;
    check("rstw_no_res", bus.result_valid_out, 1'b0);
    step();
    check("rstw_no_res2", bus.result_valid_out, 1'b0);
    check("rstw_count2", bus.block_count_out, '0);
    check("rstw_result", bus.result_out, '0);

    // Reset mid-collection discards the partial bytes; then counter wrap
    push(8'hDE, 1'b0); push(8'hAD, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    check("wrap_rst_count", bus_w.block_count_out, '0);
    for (int i = 0; i < 5; i++) begin
      push_full(8'h40 + 8'(16*i), 1'b0);
      check("wrap_block", bus.cipher_block_out, seq_block(8'h40 + 8'(16*i)));
      step();
      complete({4{32'(i)}}, i + 1);
      check("wrap_count_w", bus_w.block_count_out, 128'(wrap_exp[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
